// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory fetch, EXTEND prefix folding,
// odd-parity tagging and a 2-entry decode buffer with branch flush.
module instr_fetch #(
    parameter logic [11:0] RESET_PC = 12'h800
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [15:0] dec_instr,
    output logic        dec_extracode,
    output logic [11:0] dec_pc,
    output logic        dec_parity_err,
    input  logic        branch_valid,
    input  logic [11:0] branch_target,
    output logic        o_dbg_state
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Handshake: mem_req/mem_addr are held from issue until the cycle mem_ack=1
    // (one request in flight); a decode pop happens on any edge with dec_valid && dec_ready.
    logic [0:0]  r_state;
    logic [11:0] r_pc;
    logic        r_req;
    logic [11:0] r_addr;
    logic        r_ext;
    logic [1:0]  r_count;
    logic        r_rd;
    logic        r_wr;
    logic [15:0] r_instr [2];
    logic        r_extc  [2];
    logic [11:0] r_epc   [2];
    logic        r_perr  [2];

    logic w_ack;
    logic w_perr;
    logic w_is_ext;
    logic w_accept;
    logic w_push;
    logic w_consume_ext;
    logic w_pop;
    logic w_issue;

    assign w_ack    = r_req && mem_ack;
    assign w_perr   = ~(^mem_rdata);
    assign w_is_ext = (mem_rdata[15:1] == 15'o00006);
    // Data is only taken in FETCH with no flush in the same edge; DRAIN acks are stale.
    assign w_accept      = w_ack && (r_state == ST_FETCH) && !branch_valid;
    assign w_consume_ext = w_accept && w_is_ext && !w_perr;
    assign w_push        = w_accept && !(w_is_ext && !w_perr);
    assign w_pop         = dec_valid && dec_ready;
    assign w_issue       = (r_state == ST_FETCH) && !r_req && (r_count <= 2'd1) && !branch_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= 12'h000;
            r_ext   <= 1'b0;
            r_count <= 2'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_instr[i] <= 16'h0000;
                r_extc[i]  <= 1'b0;
                r_epc[i]   <= 12'h000;
                r_perr[i]  <= 1'b0;
            end
        end else begin
            if (w_ack) begin
                r_req <= 1'b0;
            end else if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= r_pc;
            end

            case (r_state)
                ST_FETCH: if (branch_valid && r_req && !mem_ack) r_state <= ST_DRAIN;
                ST_DRAIN: if (mem_ack) r_state <= ST_FETCH;
                default:  r_state <= ST_FETCH;
            endcase

            if (branch_valid) begin
                r_pc <= branch_target;
            end else if (w_accept) begin
                r_pc <= r_pc + 12'd1;
            end

            // A parity-failed EXTEND is pushed as data and leaves the prefix state alone.
            if (branch_valid) begin
                r_ext <= 1'b0;
            end else if (w_consume_ext) begin
                r_ext <= 1'b1;
            end else if (w_push && !w_is_ext) begin
                r_ext <= 1'b0;
            end

            if (branch_valid) begin
                r_count <= 2'd0;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_instr[r_wr] <= mem_rdata;
                    r_extc[r_wr]  <= r_ext;
                    r_epc[r_wr]   <= r_addr;
                    r_perr[r_wr]  <= w_perr;
                    r_wr          <= ~r_wr;
                end
                if (w_pop) begin
                    r_rd <= ~r_rd;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    assign mem_req        = r_req;
    assign mem_addr       = r_addr;
    assign dec_valid      = (r_count != 2'd0);
    assign dec_instr      = dec_valid ? r_instr[r_rd] : 16'h0000;
    assign dec_extracode  = dec_valid ? r_extc[r_rd]  : 1'b0;
    assign dec_pc         = dec_valid ? r_epc[r_rd]   : 12'h000;
    assign dec_parity_err = dec_valid ? r_perr[r_rd]  : 1'b0;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of fetched words, hand-written corner sequences,
// and a randomized run against a fetch-stream reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic        dec_extracode;
    logic [11:0] dec_pc;
    logic        dec_parity_err;
    logic        branch_valid;
    logic [11:0] branch_target;
    logic        o_dbg_state;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(12'h800)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_extracode(dec_extracode), .dec_pc(dec_pc), .dec_parity_err(dec_parity_err),
        .branch_valid(branch_valid), .branch_target(branch_target), .o_dbg_state(o_dbg_state)
    );

    typedef struct packed {
        logic [15:0] word;
        logic [11:0] addr;
        logic        push;
        logic        ext;
        logic        perr;
    } vec_t;

    vec_t        tbl [8];
    logic [29:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ack = 1'b0; branch_valid = 1'b0; dec_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk(name, mem_req, 1'b1);
    endtask

    task automatic ack_word(input logic [15:0] w);
        mem_ack = 1'b1; mem_rdata = w;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'($urandom);
    endtask

    function automatic logic odd_ok(input logic [15:0] w);
        int ones = 0;
        for (int b = 0; b < 16; b++) ones += int'(w[b]);
        return (ones % 2) == 1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] m_pc, req_addr, tgt;
        logic        outst, stale, m_ext, br, ack, rdy, pop, is_ext, perr;
        logic [15:0] w;
        int          acks, n_pops;

        tbl[0] = '{16'h3001, 12'h800, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 12'h801, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h000D, 12'h802, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h000D, 12'h803, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h3001, 12'h804, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'h0007, 12'h805, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'h000C, 12'h806, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{16'h8000, 12'h807, 1'b1, 1'b0, 1'b0};

        mem_rdata = 16'h0; branch_target = 12'h0;
        do_reset();
        reset = 1'b1;
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset dec_valid", dec_valid, 1'b0);
        chk("reset dec_instr", dec_instr, 16'h0);
        chk("reset dec_extracode", dec_extracode, 1'b0);
        chk("reset dec_pc", dec_pc, 12'h0);
        chk("reset dec_parity_err", dec_parity_err, 1'b0);
        chk("reset state", o_dbg_state, 1'b0);
        reset = 1'b0;

        // Table: dec_ready held high, every request acked as soon as seen
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_req("tbl req");
            chk("tbl mem_addr", mem_addr, tbl[i].addr);
            ack_word(tbl[i].word);
            chk("tbl dec_valid", dec_valid, tbl[i].push);
            if (tbl[i].push) begin
                chk("tbl dec_instr", dec_instr, tbl[i].word);
                chk("tbl dec_extracode", dec_extracode, tbl[i].ext);
                chk("tbl dec_pc", dec_pc, tbl[i].addr);
                chk("tbl dec_parity_err", dec_parity_err, tbl[i].perr);
            end
        end

        // Backpressure: only two words fit, then fetching stops until a pop
        do_reset();
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 8 && !mem_req; n++) tick();
            if (mem_req) begin
                ack_word(16'h0007);
                acks++;
            end
        end
        chk("bp push count", acks, 2);
        chk("bp mem_req idle", mem_req, 1'b0);
        chk("bp dec_valid", dec_valid, 1'b1);
        chk("bp head pc", dec_pc, 12'h800);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("bp head pc after pop", dec_pc, 12'h801);
        wait_req("bp req after pop");
        chk("bp mem_addr after pop", mem_addr, 12'h802);

        // Branch during an outstanding request, ack two cycles later
        do_reset();
        dec_ready = 1'b1;
        wait_req("br req0");
        chk("br addr0", mem_addr, 12'h800);
        ack_word(16'h000D);
        chk("br extend not pushed", dec_valid, 1'b0);
        wait_req("br req1");
        chk("br addr1", mem_addr, 12'h801);
        branch_valid = 1'b1; branch_target = 12'h123;
        tick();
        branch_valid = 1'b0;
        chk("br drain state", o_dbg_state, 1'b1);
        chk("br drain req held", mem_req, 1'b1);
        chk("br drain addr held", mem_addr, 12'h801);
        tick();
        ack_word(16'h3001);
        chk("br stale discarded", dec_valid, 1'b0);
        chk("br back to fetch", o_dbg_state, 1'b0);
        wait_req("br req target");
        chk("br target addr", mem_addr, 12'h123);
        ack_word(16'h0007);
        chk("br target valid", dec_valid, 1'b1);
        chk("br ext cleared", dec_extracode, 1'b0);
        chk("br target pc", dec_pc, 12'h123);

        // Same-cycle ack and branch to 12'hFFF, then wrap
        do_reset();
        dec_ready = 1'b1;
        wait_req("wrap req0");
        mem_ack = 1'b1; mem_rdata = 16'h3001; branch_valid = 1'b1; branch_target = 12'hFFF;
        tick();
        mem_ack = 1'b0; branch_valid = 1'b0;
        chk("wrap ack discarded", dec_valid, 1'b0);
        wait_req("wrap req fff");
        chk("wrap addr fff", mem_addr, 12'hFFF);
        ack_word(16'h0007);
        chk("wrap valid", dec_valid, 1'b1);
        chk("wrap pc fff", dec_pc, 12'hFFF);
        wait_req("wrap req 000");
        chk("wrap addr 000", mem_addr, 12'h000);

        // Reset with a same-cycle ack during an outstanding request
        do_reset();
        wait_req("rst req0");
        ack_word(16'h3001);
        chk("rst pre valid", dec_valid, 1'b1);
        wait_req("rst req1");
        chk("rst addr1", mem_addr, 12'h801);
        mem_ack = 1'b1; mem_rdata = 16'h0007; reset = 1'b1;
        tick();
        reset = 1'b0; mem_ack = 1'b0;
        chk("rst no push", dec_valid, 1'b0);
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst dec_instr", dec_instr, 16'h0);
        wait_req("rst req after");
        chk("rst addr after", mem_addr, 12'h800);

        // Randomized run against the fetch-stream model
        do_reset();
        m_pc = 12'h800; outst = 1'b0; stale = 1'b0; m_ext = 1'b0; req_addr = 12'h0;
        exp_q.delete();
        n_pops = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd dec_valid", dec_valid, exp_q.size() != 0);
            if (exp_q.size() != 0)
                chk("rnd head", {dec_instr, dec_extracode, dec_pc, dec_parity_err}, exp_q[0]);
            if (outst) begin
                chk("rnd req held", mem_req, 1'b1);
                chk("rnd addr held", mem_addr, req_addr);
            end else if (mem_req) begin
                chk("rnd req addr", mem_addr, m_pc);
                chk("rnd issue with room", exp_q.size() <= 1, 1'b1);
                outst = 1'b1; stale = 1'b0; req_addr = mem_addr;
            end

            br  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 12'(12'hFFE + $urandom_range(0, 1)) : 12'($urandom);
            ack = mem_req && ($urandom_range(0, 1) == 1);
            w   = ($urandom_range(0, 3) == 0) ? {15'o00006, 1'($urandom)} : 16'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            branch_valid = br; branch_target = tgt;
            mem_ack = ack; mem_rdata = w; dec_ready = rdy;

            pop = (exp_q.size() != 0) && rdy;
            if (pop) n_pops++;
            if (br) begin
                exp_q.delete();
                m_ext = 1'b0;
                m_pc  = tgt;
                if (outst && !ack) stale = 1'b1;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (ack && !stale) begin
                    perr   = !odd_ok(w);
                    is_ext = (w[15:1] == 15'o00006);
                    if (is_ext && !perr) begin
                        m_ext = 1'b1;
                    end else begin
                        exp_q.push_back({w, m_ext, req_addr, perr});
                        if (!is_ext) m_ext = 1'b0;
                    end
                    m_pc = m_pc + 12'd1;
                end
            end
            if (ack) outst = 1'b0;
            tick();
        end
        branch_valid = 1'b0; mem_ack = 1'b0; dec_ready = 1'b0;
        chk("rnd progress", n_pops > 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
